// File: rtl/game_tick_scheduler.sv
// Per-channel millisecond period counters feeding a round-robin arbiter
// that hands the shared update datapath to one subsystem at a time.
module game_tick_scheduler #(
  parameter int NCH        = 4,
  parameter int PW         = 8,
  parameter int DEF_PERIOD = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_1ms,
  input  logic           pause,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_sel,
  input  logic [PW-1:0]  cfg_period,
  input  logic           done,
  input  logic           ovr_clr,
  output logic [NCH-1:0] grant,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] overrun
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [PW-1:0]   cnt    [NCH];
  logic [PW-1:0]   period [NCH];
  logic [NCH-1:0]  cfg_hit;
  logic [NCH-1:0]  expire;
  logic [NCH-1:0]  take;
  logic [1:0]      rr_ptr;
  logic [1:0]      win;
  logic [1:0]      win_next;
  logic            found;
  int              idx;

  // A config write to a channel masks that channel's tick in the same cycle.
  always_comb begin
    cfg_hit = '0;
    expire  = '0;
    for (int i = 0; i < NCH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_sel == 2'(i));
      expire[i]  = tick_1ms && !pause && !cfg_hit[i] &&
                   (period[i] != '0) && (cnt[i] == period[i] - PW'(1));
    end
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!found && pending[idx]) begin
        win   = 2'(idx);
        found = 1'b1;
      end
    end
    win_next = 2'((int'(win) + 1) % NCH);
    take     = (state == IDLE && pending != '0) ? (NCH'(1) << win) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        period[i] <= PW'(DEF_PERIOD);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_hit[i]) begin
          period[i] <= cfg_period;
          cnt[i]    <= '0;
        end else if (tick_1ms && !pause && period[i] != '0) begin
          cnt[i] <= (cnt[i] == period[i] - PW'(1)) ? '0 : cnt[i] + PW'(1);
        end
      end
    end
  end

  // A winner's pending bit is consumed in the grant cycle, so a fresh expiry
  // on that channel re-queues it without counting as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      pending <= '0;
      overrun <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= (pending & ~take) | expire;
      overrun <= (ovr_clr ? '0 : overrun) | (expire & pending & ~take);
      case (state)
        IDLE: begin
          if (pending != '0) begin
            grant  <= take;
            rr_ptr <= win_next;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (done) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: periods, RR order, overrun, pause, reset.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1ms;
  logic       pause;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_period;
  logic       done;
  logic       ovr_clr;
  logic [3:0] grant;
  logic [3:0] pending;
  logic [3:0] overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         gcnt     = 0;
  logic [3:0] prev_grant = '0;
  logic [3:0] glog [$];
  int         gcyc [$];

  game_tick_scheduler #(.NCH(4), .PW(8), .DEF_PERIOD(10)) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .pause(pause),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_period(cfg_period),
    .done(done), .ovr_clr(ovr_clr),
    .grant(grant), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task sampleGrant();
    cyc++;
    if (grant != '0 && grant != prev_grant) begin
      glog.push_back(grant);
      gcyc.push_back(cyc);
    end
    prev_grant = grant;
    gcnt = (grant != '0) ? gcnt + 1 : 0;
  endtask

  // Runs ncycles; nticks ticks spaced gap apart starting at cycle 0; the
  // consumer raises done once a grant has been seen done_delay times (-1 = never).
  task applyStimulus(input int ncycles, input int gap, input int nticks, input int done_delay);
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      sampleGrant();
      done     = (done_delay >= 0) && (grant != '0) && (gcnt >= done_delay);
      tick_1ms = (gap > 0) && ((c % gap) == 0) && ((c / gap) < nticks);
    end
    @(negedge clk);
    sampleGrant();
    tick_1ms = 1'b0;
    done     = 1'b0;
  endtask

  task writePeriod(input logic [1:0] sel, input logic [7:0] p);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_period = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task clearLog();
    glog.delete();
    gcyc.delete();
  endtask

  task checkLog(input string tag, input int n, input logic [31:0] exp_pack);
    logic [3:0] got;
    checkOutput({tag, "_count"}, glog.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < glog.size()) ? glog[i] : 4'hF;
      checkOutput($sformatf("%s_%0d", tag, i), int'(got), int'(exp_pack[4*i +: 4]));
    end
  endtask

  initial begin
    rst = 1'b1; tick_1ms = 1'b0; pause = 1'b0; cfg_we = 1'b0;
    cfg_sel = '0; cfg_period = '0; done = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_grant",   int'(grant),   0);
    checkOutput("reset_pending", int'(pending), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Default periods: all four expire together at ticks 10 and 20.
    clearLog();
    applyStimulus(200, 8, 25, 2);
    checkLog("t1_order", 8, 32'h8421_8421);
    checkOutput("t1_overrun", int'(overrun), 0);
    checkOutput("t1_pending", int'(pending), 0);

    writePeriod(2'd1, 8'd3);
    writePeriod(2'd0, 8'd0);
    writePeriod(2'd2, 8'd0);
    writePeriod(2'd3, 8'd0);
    clearLog();
    applyStimulus(72, 8, 9, 2);
    checkLog("t2_ch1", 3, 32'h0000_0222);

    // Period 1 with the consumer stalled: re-queue, then overrun.
    writePeriod(2'd0, 8'd1);
    writePeriod(2'd1, 8'd0);
    clearLog();
    applyStimulus(8, 8, 1, -1);
    checkOutput("t3_tick1_grant",   int'(grant),   1);
    checkOutput("t3_tick1_pending", int'(pending), 0);
    applyStimulus(8, 8, 1, -1);
    checkOutput("t3_tick2_pending", int'(pending), 1);
    checkOutput("t3_tick2_overrun", int'(overrun), 0);
    applyStimulus(8, 8, 1, -1);
    checkOutput("t3_tick3_overrun", int'(overrun), 1);
    checkOutput("t3_tick3_grant",   int'(grant),   1);
    @(negedge clk); tick_1ms = 1'b1; ovr_clr = 1'b1;
    @(negedge clk); tick_1ms = 1'b0; ovr_clr = 1'b0;
    checkOutput("t3_set_beats_clr", int'(overrun), 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    checkOutput("t3_ovr_clr", int'(overrun), 0);
    writePeriod(2'd0, 8'd0);
    clearLog();
    applyStimulus(20, 1, 0, 0);
    checkLog("t3_drain", 1, 32'h1);
    checkOutput("t3_drain_pending", int'(pending), 0);

    // Park rr_ptr at 2 via one ch1 grant, then expire all four together.
    writePeriod(2'd1, 8'd1);
    clearLog();
    applyStimulus(8, 8, 1, 2);
    checkLog("t4_setup", 1, 32'h2);
    writePeriod(2'd0, 8'd2);
    writePeriod(2'd1, 8'd2);
    writePeriod(2'd2, 8'd2);
    writePeriod(2'd3, 8'd2);
    clearLog();
    applyStimulus(36, 8, 2, 2);
    checkLog("t4_order", 4, 32'h0000_2184);
    for (int i = 0; i < 3; i++)
      if (gcyc.size() > i + 1)
        checkOutput($sformatf("t4_spacing_%0d", i), gcyc[i+1] - gcyc[i], 3);
    checkOutput("t4_pending", int'(pending), 0);

    writePeriod(2'd0, 8'd1);
    writePeriod(2'd1, 8'd0);
    writePeriod(2'd2, 8'd5);
    writePeriod(2'd3, 8'd0);
    clearLog();
    applyStimulus(16, 8, 2, -1);
    checkOutput("t5_pre_grant",   int'(grant),   1);
    checkOutput("t5_pre_pending", int'(pending), 1);
    pause = 1'b1;
    clearLog();
    applyStimulus(160, 8, 20, -1);
    checkOutput("t5_pause_pending", int'(pending), 1);
    checkOutput("t5_pause_overrun", int'(overrun), 0);
    checkOutput("t5_pause_nogrant", glog.size(), 0);
    applyStimulus(20, 1, 0, 2);
    checkLog("t5_pause_drain", 1, 32'h1);
    checkOutput("t5_drained", int'(pending), 0);
    writePeriod(2'd0, 8'd0);
    pause = 1'b0;
    clearLog();
    applyStimulus(16, 8, 2, 2);
    checkOutput("t5_resume_early", int'(pending | grant), 0);
    applyStimulus(16, 8, 1, 2);
    checkLog("t5_resume", 1, 32'h4);

    clearLog();
    applyStimulus(40, 8, 5, -1);
    checkOutput("t6_held", int'(grant), 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_async_grant", int'(grant), 0);
    @(negedge clk);
    rst = 1'b0;
    prev_grant = '0;
    gcnt = 0;
    checkOutput("t6_overrun", int'(overrun), 0);
    clearLog();
    applyStimulus(72, 8, 9, 2);
    checkOutput("t6_nine_ticks", glog.size(), 0);
    checkOutput("t6_nine_pending", int'(pending), 0);
    applyStimulus(40, 8, 1, 2);
    checkLog("t6_default", 4, 32'h0000_8421);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
